// File: rtl/and_gate_exerciser_if.sv
// Stimulus/response bundle between the AND-gate exerciser and the gate plus its controller.
// master = exerciser side; slave = gate/controller side.
interface and_gate_exerciser_if;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic       fail_valid;
  logic [2:0] fail_vec;

  modport master (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/and_gate_exerciser.sv
// Drives 00,01,10,11 into a 2-input AND gate, samples y after HOLD_CYCLES and reports errors.
// Optional macro GATE_EXERCISER_LOOP_EN: start on the last sample repeats the pass without DONE.
module and_gate_exerciser #(
  parameter int unsigned HOLD_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  and_gate_exerciser_if.master  bus
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned ERR_W     = 8;
  localparam int unsigned VEC_W     = 2;
  localparam int unsigned HOLD_LAST = HOLD_CYCLES - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [VEC_W-1:0]   vec_idx_q, vec_idx_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               fail_valid_q, fail_valid_d;
  logic [2:0]         fail_vec_q, fail_vec_d;

  logic sample_c;
  logic last_c;
  logic mismatch_c;
  logic loop_c;

  // Sample point is the final cycle of each vector's hold window.
  assign sample_c   = (state_q == ST_RUN) && (hold_cnt_q == CNT_W'(HOLD_LAST));
  assign last_c     = sample_c && (vec_idx_q == VEC_W'(3));
  assign mismatch_c = sample_c && (bus.y_in != (a_q & b_q));

`ifdef GATE_EXERCISER_LOOP_EN
  assign loop_c = last_c && bus.start;
`else
  assign loop_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (bus.start) state_d = ST_RUN;
      ST_RUN:           if (last_c && !loop_c) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    vec_idx_d    = vec_idx_q;
    a_d          = 1'b0;
    b_d          = 1'b0;
    busy_d       = 1'b0;
    done_d       = done_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          hold_cnt_d   = '0;
          vec_idx_d    = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (sample_c) begin
          hold_cnt_d = '0;
          vec_idx_d  = vec_idx_q + VEC_W'(1);
          if (mismatch_c) begin
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = {a_q, b_q, bus.y_in};
            end
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
        // Final sample ends the run; pass must include that sample's verdict.
        if (last_c && !loop_c) begin
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = (err_cnt_d == '0);
          vec_idx_d = '0;
        end else begin
          a_d = vec_idx_d[1];
          b_d = vec_idx_d[0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q   <= '0;
      vec_idx_q    <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      vec_idx_q    <= vec_idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_and_gate_exerciser.sv
// Directed bench for and_gate_exerciser: gate models AND, stuck-0, stuck-1 and OR, plus reset abort.
module tb_and_gate_exerciser;

  localparam int unsigned HOLD = 5;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  int         checks;
  int         errors;

  and_gate_exerciser_if bus ();

  and_gate_exerciser #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Gate under test: 0 = AND, 1 = stuck 0, 2 = stuck 1, 3 = OR
  assign bus.y_in = (mode == 2'd0) ? (bus.a_out & bus.b_out) :
                    (mode == 2'd1) ? 1'b0 :
                    (mode == 2'd2) ? 1'b1 : (bus.a_out | bus.b_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_a"},     8'(bus.a_out),      8'd0);
    chk({tag, "_b"},     8'(bus.b_out),      8'd0);
    chk({tag, "_busy"},  8'(bus.busy),       8'd0);
    chk({tag, "_done"},  8'(bus.done),       8'd0);
    chk({tag, "_pass"},  8'(bus.pass),       8'd0);
    chk({tag, "_err"},   bus.err_cnt,        8'd0);
    chk({tag, "_fval"},  8'(bus.fail_valid), 8'd0);
    chk({tag, "_fvec"},  8'(bus.fail_vec),   8'd0);
  endtask

  // One pass: start pulse, watch 4*HOLD busy cycles, then check the DONE report.
  task automatic run_case(input string tag, input logic [1:0] m, input logic mid_pulse,
                          input logic [7:0] e_err, input logic [2:0] e_fvec,
                          input logic e_fval, input logic e_pass);
    mode = m;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, "_done_clr"}, 8'(bus.done),       8'd0);
    chk({tag, "_err_clr"},  bus.err_cnt,        8'd0);
    chk({tag, "_fval_clr"}, 8'(bus.fail_valid), 8'd0);
    for (int i = 0; i < 4 * HOLD; i++) begin
      chk({tag, "_busy"}, 8'(bus.busy), 8'd1);
      chk({tag, "_ab"},   8'({bus.a_out, bus.b_out}), 8'(i / HOLD));
      if (mid_pulse && i == 7) bus.start = 1'b1;
      if (mid_pulse && i == 8) bus.start = 1'b0;
      step();
    end
    chk({tag, "_busy_end"}, 8'(bus.busy),       8'd0);
    chk({tag, "_done"},     8'(bus.done),       8'd1);
    chk({tag, "_ab_end"},   8'({bus.a_out, bus.b_out}), 8'd0);
    chk({tag, "_pass"},     8'(bus.pass),       8'(e_pass));
    chk({tag, "_err"},      bus.err_cnt,        e_err);
    chk({tag, "_fval"},     8'(bus.fail_valid), 8'(e_fval));
    chk({tag, "_fvec"},     8'(bus.fail_vec),   8'(e_fvec));
    step();
    chk({tag, "_hold_done"}, 8'(bus.done),    8'd1);
    chk({tag, "_hold_err"},  bus.err_cnt,     e_err);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mode      = 2'd0;
    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) step();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (3) step();
    chk_idle_outputs("idle");

    run_case("and",   2'd0, 1'b0, 8'd0, 3'b000, 1'b0, 1'b1);
    run_case("tie0",  2'd1, 1'b0, 8'd1, 3'b110, 1'b1, 1'b0);
    run_case("tie1",  2'd2, 1'b0, 8'd3, 3'b001, 1'b1, 1'b0);
    run_case("or",    2'd3, 1'b0, 8'd2, 3'b011, 1'b1, 1'b0);
    run_case("tie0b", 2'd1, 1'b0, 8'd1, 3'b110, 1'b1, 1'b0);
    run_case("midst", 2'd0, 1'b1, 8'd0, 3'b000, 1'b0, 1'b1);

    // Reset abort while vector 10 is driven.
    mode = 2'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (12) step();
    chk("abort_ab_pre", 8'({bus.a_out, bus.b_out}), 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    chk_idle_outputs("abort_idle");
    run_case("post_rst", 2'd0, 1'b0, 8'd0, 3'b000, 1'b0, 1'b1);

`ifdef GATE_EXERCISER_LOOP_EN
    // Three back-to-back passes with start held, then release before the third wrap point.
    mode = 2'd1;
    bus.start = 1'b1;
    step();
    repeat (8 * HOLD) begin
      chk("loop_busy", 8'(bus.busy), 8'd1);
      step();
    end
    bus.start = 1'b0;
    repeat (4 * HOLD) step();
    chk("loop_done", 8'(bus.done),    8'd1);
    chk("loop_err",  bus.err_cnt,     8'd3);
    chk("loop_fvec", 8'(bus.fail_vec), 8'b110);
    chk("loop_pass", 8'(bus.pass),    8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
